// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the EX-stage branch resolver: comparison codes, BHT reset value and
// the FSM state type.
package branch_resolve_ctrl_pkg;

  localparam int unsigned RF_XLEN   = 32;
  localparam int unsigned BR_OPSLEN = 3;

  // Conditional codes follow the RV32 B-type funct3 values; 2 marks jumps, 3 is unused.
  localparam logic [BR_OPSLEN-1:0] BR_OPS_EQ     = 3'd0;
  localparam logic [BR_OPSLEN-1:0] BR_OPS_NE     = 3'd1;
  localparam logic [BR_OPSLEN-1:0] BR_OPS_UNCOND = 3'd2;
  localparam logic [BR_OPSLEN-1:0] BR_OPS_LT     = 3'd4;
  localparam logic [BR_OPSLEN-1:0] BR_OPS_GE     = 3'd5;
  localparam logic [BR_OPSLEN-1:0] BR_OPS_LTU    = 3'd6;
  localparam logic [BR_OPSLEN-1:0] BR_OPS_GEU    = 3'd7;

  localparam logic [1:0] BHT_CNT_RESET = 2'b01;

  typedef enum logic {
    IDLE,
    REDIRECT
  } brc_state_t;

  function automatic logic is_cond_op(logic [BR_OPSLEN-1:0] op);
    return (op == BR_OPS_EQ)  || (op == BR_OPS_NE)  || (op == BR_OPS_LT) ||
           (op == BR_OPS_GE)  || (op == BR_OPS_LTU) || (op == BR_OPS_GEU);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Bundle of EX-stage branch inputs, fetch prediction/redirect signals and statistics.
interface branch_resolve_ctrl_if
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = RF_XLEN
);

  logic                 ex_valid;
  logic [BR_OPSLEN-1:0] ex_br_op;
  logic [XLEN-1:0]      ex_rs1;
  logic [XLEN-1:0]      ex_rs2;
  logic [XLEN-1:0]      ex_pc;
  logic [XLEN-1:0]      ex_target;
  logic                 ex_pred_taken;
  logic [XLEN-1:0]      if_pc;
  logic                 if_pred_taken;
  logic                 redir_valid;
  logic                 redir_ready;
  logic [XLEN-1:0]      redir_pc;
  logic                 flush;
  logic [31:0]          stat_branches;
  logic [31:0]          stat_mispredicts;

  modport master (
    output ex_valid, ex_br_op, ex_rs1, ex_rs2, ex_pc, ex_target, ex_pred_taken, if_pc,
           redir_ready,
    input  if_pred_taken, redir_valid, redir_pc, flush, stat_branches, stat_mispredicts
  );

  modport slave (
    input  ex_valid, ex_br_op, ex_rs1, ex_rs2, ex_pc, ex_target, ex_pred_taken, if_pc,
           redir_ready,
    output if_pred_taken, redir_valid, redir_pc, flush, stat_branches, stat_mispredicts
  );

endinterface

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating counters: combinational read, synchronous update.
module bht_2bit
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 64,
  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_taken,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  logic [1:0] r_cnt [BHT_ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        r_cnt[i] <= BHT_CNT_RESET;
      end
    end else if (i_upd_en) begin
      if (i_upd_taken && (r_cnt[i_upd_idx] != 2'b11)) begin
        r_cnt[i_upd_idx] <= r_cnt[i_upd_idx] + 2'b01;
      end else if (!i_upd_taken && (r_cnt[i_upd_idx] != 2'b00)) begin
        r_cnt[i_upd_idx] <= r_cnt[i_upd_idx] - 2'b01;
      end
    end
  end

  // Read sees the registered value, so a same-cycle update is not forwarded.
  assign o_rd_taken = r_cnt[i_rd_idx][1];

endmodule

// File: rtl/branch_condition.sv
// Evaluates a branch comparison code on two operands; jumps are always taken.
module branch_condition
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = RF_XLEN
) (
  input  logic [BR_OPSLEN-1:0] i_op,
  input  logic [XLEN-1:0]      i_a,
  input  logic [XLEN-1:0]      i_b,
  output logic                 o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_op)
      BR_OPS_EQ:     o_taken = (i_a == i_b);
      BR_OPS_NE:     o_taken = (i_a != i_b);
      BR_OPS_LT:     o_taken = ($signed(i_a) <  $signed(i_b));
      BR_OPS_GE:     o_taken = ($signed(i_a) >= $signed(i_b));
      BR_OPS_LTU:    o_taken = (i_a <  i_b);
      BR_OPS_GEU:    o_taken = (i_a >= i_b);
      BR_OPS_UNCOND: o_taken = 1'b1;
      default:       o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolver: checks predictions, holds a redirect/flush until fetch accepts it,
// trains the bimodal BHT and counts branches and mispredicts.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = RF_XLEN,
  parameter int unsigned BHT_ENTRIES = 64
) (
  input logic                clk,
  input logic                rst,
  branch_resolve_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  brc_state_t      r_state;
  logic [XLEN-1:0] r_redir_pc;
  logic [31:0]     r_stat_br;
  logic [31:0]     r_stat_mis;

  logic             w_taken;
  logic             w_accept;
  logic             w_mispredict;
  logic [IDX_W-1:0] w_ex_idx;
  logic [IDX_W-1:0] w_if_idx;
  logic             w_unused_if_pc;

  assign w_ex_idx       = bus.ex_pc[IDX_W+1:2];
  assign w_if_idx       = bus.if_pc[IDX_W+1:2];
  assign w_unused_if_pc = ^{bus.if_pc[XLEN-1:IDX_W+2], bus.if_pc[1:0]};

  branch_condition #(
    .XLEN (XLEN)
  ) u_branch_condition (
    .i_op    (bus.ex_br_op),
    .i_a     (bus.ex_rs1),
    .i_b     (bus.ex_rs2),
    .o_taken (w_taken)
  );

  assign w_accept     = (r_state == IDLE) && bus.ex_valid;
  assign w_mispredict = w_taken ^ bus.ex_pred_taken;

  bht_2bit #(
    .BHT_ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (w_if_idx),
    .o_rd_taken  (bus.if_pred_taken),
    .i_upd_en    (w_accept && is_cond_op(bus.ex_br_op)),
    .i_upd_idx   (w_ex_idx),
    .i_upd_taken (w_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_redir_pc <= '0;
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_stat_br <= r_stat_br + 32'd1;
            if (w_mispredict) begin
              r_stat_mis <= r_stat_mis + 32'd1;
              r_redir_pc <= w_taken ? bus.ex_target : (bus.ex_pc + XLEN'(4));
              r_state    <= REDIRECT;
            end
          end
        end
        REDIRECT: begin
          // Anything in EX now is wrong-path; just wait for fetch to take the redirect.
          if (bus.redir_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.redir_valid      = (r_state == REDIRECT);
  assign bus.flush            = (r_state == REDIRECT);
  assign bus.redir_pc         = r_redir_pc;
  assign bus.stat_branches    = r_stat_br;
  assign bus.stat_mispredicts = r_stat_mis;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed and randomized checks of branch_resolve_ctrl against a behavioural model.
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  logic clk;
  logic rst;

  branch_resolve_ctrl_if #(.XLEN(32)) bus ();

  branch_resolve_ctrl #(
    .XLEN        (32),
    .BHT_ENTRIES (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_pass;

  // Reference state
  int          m_bht [64];
  bit          m_redir;
  logic [31:0] m_pc;
  logic [31:0] m_br;
  logic [31:0] m_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic bit model_taken(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      BR_OPS_EQ:     return a == b;
      BR_OPS_NE:     return a != b;
      BR_OPS_LT:     return $signed(a) < $signed(b);
      BR_OPS_GE:     return $signed(a) >= $signed(b);
      BR_OPS_LTU:    return a < b;
      BR_OPS_GEU:    return a >= b;
      BR_OPS_UNCOND: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic int bht_idx(logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  task automatic model_reset();
    m_redir = 0;
    m_pc    = 0;
    m_br    = 0;
    m_mis   = 0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
  endtask

  task automatic model_clock();
    bit t;
    int k;
    if (!m_redir) begin
      if (bus.ex_valid) begin
        t = model_taken(bus.ex_br_op, bus.ex_rs1, bus.ex_rs2);
        m_br = m_br + 1;
        if (t != bus.ex_pred_taken) begin
          m_mis   = m_mis + 1;
          m_pc    = t ? bus.ex_target : bus.ex_pc + 32'd4;
          m_redir = 1;
        end
        if (bus.ex_br_op inside {BR_OPS_EQ, BR_OPS_NE, BR_OPS_LT, BR_OPS_GE,
                                 BR_OPS_LTU, BR_OPS_GEU}) begin
          k = bht_idx(bus.ex_pc);
          if (t) m_bht[k] = (m_bht[k] < 3) ? m_bht[k] + 1 : 3;
          else   m_bht[k] = (m_bht[k] > 0) ? m_bht[k] - 1 : 0;
        end
      end
    end else if (bus.redir_ready) begin
      m_redir = 0;
    end
  endtask

  task automatic drive(input bit v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [31:0] tgt,
                       input bit pred, input bit rdy, input logic [31:0] ifpc);
    bus.ex_valid      = v;
    bus.ex_br_op      = op;
    bus.ex_rs1        = a;
    bus.ex_rs2        = b;
    bus.ex_pc         = pc;
    bus.ex_target     = tgt;
    bus.ex_pred_taken = pred;
    bus.redir_ready   = rdy;
    bus.if_pc         = ifpc;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    #1;
    check("if_pred", {31'd0, bus.if_pred_taken}, {31'd0, m_bht[bht_idx(bus.if_pc)] >= 2});
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check("redir_valid", {31'd0, bus.redir_valid}, {31'd0, m_redir});
    check("flush", {31'd0, bus.flush}, {31'd0, m_redir});
    check("redir_pc", bus.redir_pc, m_pc);
    check("stat_br", bus.stat_branches, m_br);
    check("stat_mis", bus.stat_mispredicts, m_mis);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid", {31'd0, bus.redir_valid}, 32'd0);
    check("rst_flush", {31'd0, bus.flush}, 32'd0);
    check("rst_pc", bus.redir_pc, 32'd0);
    check("rst_br", bus.stat_branches, 32'd0);
    check("rst_mis", bus.stat_mispredicts, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, pc, ifpc;
    n_checks = 0;
    n_pass   = 0;
    clk      = 1'b0;
    rst      = 1'b1;
    drive(0, BR_OPS_EQ, 0, 0, 0, 0, 0, 0, 32'h100);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_pred_100", {31'd0, bus.if_pred_taken}, 32'd0);
    bus.if_pc = 32'h2000;
    #1;
    check("rst_pred_2000", {31'd0, bus.if_pred_taken}, 32'd0);
    @(negedge clk);
    apply_reset();

    // BEQ taken but predicted not-taken
    drive(1, BR_OPS_EQ, 5, 5, 32'h100, 32'h80, 0, 1, 32'h100);
    cycle();
    check("beq_redir_pc", bus.redir_pc, 32'h80);
    check("beq_mis", bus.stat_mispredicts, 32'd1);
    drive(0, BR_OPS_EQ, 0, 0, 0, 0, 0, 1, 32'h100);
    cycle();
    check("beq_valid_clr", {31'd0, bus.redir_valid}, 32'd0);
    #1;
    check("beq_bht_pred", {31'd0, bus.if_pred_taken}, 32'd1);
    @(negedge clk);

    // Signed versus unsigned compare of 0xFFFFFFFF against 1
    apply_reset();
    drive(1, BR_OPS_LT, 32'hFFFF_FFFF, 1, 32'h40, 32'h1000, 1, 1, 32'h40);
    cycle();
    check("blt_no_redir", {31'd0, bus.redir_valid}, 32'd0);
    drive(1, BR_OPS_LTU, 32'hFFFF_FFFF, 1, 32'h40, 32'h1000, 1, 1, 32'h40);
    cycle();
    check("bltu_pc", bus.redir_pc, 32'h44);
    check("bltu_br", bus.stat_branches, 32'd2);
    check("bltu_mis", bus.stat_mispredicts, 32'd1);
    drive(0, BR_OPS_EQ, 0, 0, 0, 0, 0, 1, 32'h40);
    cycle();

    // Backpressure: redirect held while ex_valid toggles with wrong-path mispredicts
    drive(1, BR_OPS_EQ, 1, 2, 32'h300, 32'h500, 1, 0, 32'h300);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(i % 2 == 0, BR_OPS_NE, 7, 9, 32'h600, 32'h700, 0, 0, 32'h600);
      cycle();
      check("bp_pc_held", bus.redir_pc, 32'h304);
      check("bp_br_held", bus.stat_branches, 32'd3);
    end
    drive(1, BR_OPS_NE, 7, 9, 32'h600, 32'h700, 0, 1, 32'h600);
    cycle();
    check("bp_released", {31'd0, bus.redir_valid}, 32'd0);

    // Counter saturation and jumps not training the table
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, BR_OPS_NE, 1, 2, 32'h200, 32'h900, 1, 1, 32'h200);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, BR_OPS_NE, 3, 3, 32'h200, 32'h900, 0, 1, 32'h200);
      cycle();
    end
    drive(1, BR_OPS_UNCOND, 0, 0, 32'h200, 32'h900, 1, 1, 32'h200);
    cycle();
    drive(1, BR_OPS_NE, 1, 2, 32'h200, 32'h900, 1, 1, 32'h200);
    cycle();
    drive(0, BR_OPS_EQ, 0, 0, 0, 0, 0, 1, 32'h200);
    cycle();

    // PC+4 wrap, then asynchronous reset during the redirect
    drive(1, BR_OPS_EQ, 1, 2, 32'hFFFF_FFFC, 32'h10, 1, 0, 32'h0);
    cycle();
    check("wrap_pc", bus.redir_pc, 32'h0);
    check("wrap_valid", {31'd0, bus.redir_valid}, 32'd1);
    drive(0, BR_OPS_EQ, 0, 0, 0, 0, 0, 0, 32'h0);
    apply_reset();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      a    = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
      b    = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
      pc   = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      ifpc = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b, pc,
            $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) < 3, ifpc);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences the branch comparator (`branch_condition`) in the EX stage of the pipelined RV32 core.
- Checks each resolved branch or jump against its fetch-time prediction.
- On a mispredict, issues a held redirect to fetch and flushes younger stages.
- Owns the 2-bit bimodal branch history table (BHT) that fetch reads for predictions, and keeps branch/mispredict statistics counters.

Parameters:
- XLEN, `RF_XLEN (32): datapath and PC width.
- BHT_ENTRIES, 64: number of BHT entries. Must be a power of 2. Index = pc[$clog2(BHT_ENTRIES)+1:2].

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- ex_valid  in  1  branch/jump instruction present in EX
- ex_br_op  in  `BR_OPSLEN  comparison code, using the `BR_OPS_* encoding
- ex_rs1  in  XLEN  operand a
- ex_rs2  in  XLEN  operand b
- ex_pc  in  XLEN  PC of the EX instruction
- ex_target  in  XLEN  computed branch/jump target
- ex_pred_taken  in  1  prediction made at fetch and carried down the pipe
- if_pc  in  XLEN  fetch PC for the prediction lookup
- if_pred_taken  out  1  BHT prediction for if_pc (combinational)
- redir_valid  out  1  redirect request to fetch
- redir_ready  in  1  fetch accepts the redirect
- redir_pc  out  XLEN  corrected fetch PC
- flush  out  1  kill IF/ID and ID/EX contents
- stat_branches  out  32  accepted branch count
- stat_mispredicts  out  32  mispredict count

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-redirect):
  - FSM returns to IDLE.
  - redir_valid=0, flush=0, redir_pc=0, both stat counters=0.
  - All BHT entries = 2'b01 (weakly not-taken).
- FSM states: IDLE and REDIRECT.
- Outputs by state: redir_valid = flush = (state==REDIRECT). redir_pc is registered and stays stable throughout REDIRECT.
- IDLE, ex_valid=1 (the instruction is accepted):
  - taken = branch_condition(ex_br_op, ex_rs1, ex_rs2). `BR_OPS_UNCOND gives 1; an undefined code gives 0.
  - mispredict = taken XOR ex_pred_taken.
  - stat_branches += 1. If mispredict, stat_mispredicts += 1. Both counters wrap modulo 2^32.
  - On mispredict:
    - redir_pc <= taken ? ex_target : ex_pc+4. The addition wraps modulo 2^XLEN.
    - Next state is REDIRECT, so redir_valid and flush rise in cycle N+1 for an accept in cycle N.
  - BHT update, only for the six conditional codes (EQ, NE, LT, GE, LTU, GEU):
    - Counter at index(ex_pc) saturating-increments if taken, saturating-decrements otherwise (00..11).
    - UNCOND and undefined codes leave the BHT untouched.
- REDIRECT:
  - ex_valid is ignored (wrong-path). No counter update, no BHT update.
  - Stay in REDIRECT while redir_ready=0.
  - When redir_ready=1 in a REDIRECT cycle, the handshake completes and the next state is IDLE. The earliest new branch accept is therefore cycle N+2.
- Prediction read: if_pred_taken = BHT[index(if_pc)][1].
  - If a read and a write hit the same index in the same cycle, the read returns the pre-update value.
- Only stat counters and the BHT are stateful besides the FSM. There is no internal queue: at most one redirect is outstanding.

Decomposition:
- Shared header RISCV_defs.svh holds:
  - existing `BR_OPS_*, `BR_OPSLEN and `RF_XLEN
  - a new `BHT_CNT_RESET (2'b01)
  - the FSM state enum type (brc_state_t: IDLE, REDIRECT)
- Sub-modules:
  - Instantiate the existing branch_condition for the comparison.
  - One new sub-module, bht_2bit: parameter BHT_ENTRIES, one combinational read port, one synchronous update port (en, idx, taken), async reset to `BHT_CNT_RESET.

Test Plan:
- Reset: pulse rst → all outputs 0; if_pc=0x100 and 0x2000 both give if_pred_taken=0.
- BEQ mispredict: rs1=rs2=5, ex_pred_taken=0, ex_pc=0x100, ex_target=0x80, redir_ready=1 → next cycle redir_valid=1, flush=1, redir_pc=0x80; stat_mispredicts=1; afterwards if_pc=0x100 gives if_pred_taken=1 (counter 10).
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=1, pred=1, ex_pc=0x40:
  - BLT → no redirect.
  - BLTU → redir_pc=0x44.
  - stat_branches=2, stat_mispredicts=1.
- Backpressure: mispredict with redir_ready=0 for 3 cycles while ex_valid toggles → redir_valid and flush held, redir_pc unchanged, counters unchanged; redir_ready=1 → IDLE next cycle.
- Saturation/no-update: 4× taken BNE at 0x200 → counter 11, and a 5th stays 11; then 4× not-taken → 00; JAL (UNCOND) at 0x200 leaves counter at 00.
- Wrap and reset: not-taken mispredict at ex_pc=0xFFFFFFFC → redir_pc=0x00000000; assert rst during REDIRECT → redir_valid and flush drop in the same cycle without waiting for a clock edge.
